// File: rtl/red_pitaya_trigger_hub.sv
// Multi-channel level/slope trigger: per-channel Schmitt slope detectors feed an
// IDLE/ARMED/HOLDOFF trigger FSM with a bus-mapped config, timestamp and trigger count.
module red_pitaya_trigger_hub #(
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned DATA_W    = 14,
   parameter int unsigned HOLDOFF_W = 32
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic [CHANNELS*DATA_W-1:0] dat_i,
   output logic                       trig_o,
   output logic [CHANNELS-1:0]        trig_src_o,
   output logic                       armed_o,
   input  logic [15:0]                addr,
   input  logic                       wen,
   input  logic                       ren,
   input  logic [31:0]                wdata,
   output logic                       ack,
   output logic [31:0]                rdata
);

   localparam int unsigned SRC_W = 2 * CHANNELS;
   localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   state_t                   state_q, state_nx;
   logic                     trig_nx;
   logic                     auto_q;
   logic [SRC_W-1:0]         en_q;
   logic [HOLDOFF_W-1:0]     holdoff_q, hcnt_q;
   logic signed [DATA_W-1:0] thresh_q [CHANNELS];
   logic signed [DATA_W-1:0] hyst_q   [CHANNELS];
   logic signed [DATA_W-1:0] thr_r    [CHANNELS];
   logic signed [DATA_W-1:0] thp_r    [CHANNELS];
   logic signed [DATA_W-1:0] thm_r    [CHANNELS];
   logic signed [DATA_W-1:0] dat_r    [CHANNELS];
   logic signed [DATA_W:0]   sum_p_c  [CHANNELS];
   logic signed [DATA_W:0]   sum_m_c  [CHANNELS];
   logic [CHANNELS-1:0]      pos_q, neg_q, pos_prev, neg_prev, pos_edge_q, neg_edge_q;
   logic [CHANNELS-1:0]      ev_mask_c;
   logic                     event_c, rearm_c, disarm_c;
   logic [63:0]              cnt_q, ts_q;
   logic [31:0]              tcnt_q, rd_c;

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
      if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
      else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      else                  return v[DATA_W-1:0];
   endfunction

   assign rearm_c  = wen && (addr == 16'h100) && wdata[0];
   assign disarm_c = wen && (addr == 16'h100) && wdata[1];

   // Configuration registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         auto_q    <= 1'b0;
         en_q      <= '0;
         holdoff_q <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            thresh_q[k] <= '0;
            hyst_q[k]   <= DATA_W'(20);
         end
      end else if (wen) begin
         case (addr)
            16'h104: auto_q    <= wdata[0];
            16'h108: en_q      <= wdata[SRC_W-1:0];
            16'h10C: holdoff_q <= wdata[HOLDOFF_W-1:0];
            default: ;
         endcase
         for (int k = 0; k < CHANNELS; k++) begin
            if (addr == 16'(16'h118 + 8*k)) thresh_q[k] <= wdata[DATA_W-1:0];
            if (addr == 16'(16'h11C + 8*k)) hyst_q[k]   <= wdata[DATA_W-1:0];
         end
      end
   end

   // Widened threshold +/- hysteresis so saturation replaces wraparound
   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         sum_p_c[k] = $signed({thresh_q[k][DATA_W-1], thresh_q[k]}) + $signed({hyst_q[k][DATA_W-1], hyst_q[k]});
         sum_m_c[k] = $signed({thresh_q[k][DATA_W-1], thresh_q[k]}) - $signed({hyst_q[k][DATA_W-1], hyst_q[k]});
      end
   end

   // Sample capture, Schmitt states and rising-edge pulses
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int k = 0; k < CHANNELS; k++) begin
            thr_r[k] <= '0;
            thp_r[k] <= '0;
            thm_r[k] <= '0;
            dat_r[k] <= '0;
         end
         pos_q      <= '0;
         neg_q      <= '0;
         pos_prev   <= '0;
         neg_prev   <= '0;
         pos_edge_q <= '0;
         neg_edge_q <= '0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            thr_r[k] <= thresh_q[k];
            thp_r[k] <= sat(sum_p_c[k]);
            thm_r[k] <= sat(sum_m_c[k]);
            dat_r[k] <= dat_i[k*DATA_W +: DATA_W];
            if (dat_r[k] >= thr_r[k])     pos_q[k] <= 1'b1;
            else if (dat_r[k] < thm_r[k]) pos_q[k] <= 1'b0;
            if (dat_r[k] <= thr_r[k])     neg_q[k] <= 1'b1;
            else if (dat_r[k] > thp_r[k]) neg_q[k] <= 1'b0;
         end
         pos_prev   <= pos_q;
         neg_prev   <= neg_q;
         pos_edge_q <= pos_q & ~pos_prev;
         neg_edge_q <= neg_q & ~neg_prev;
      end
   end

   always_comb begin
      ev_mask_c = '0;
      for (int k = 0; k < CHANNELS; k++)
         ev_mask_c[k] = (pos_edge_q[k] & en_q[2*k]) | (neg_edge_q[k] & en_q[2*k+1]);
   end
   assign event_c = |ev_mask_c;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= ST_IDLE;
      else         state_q <= state_nx;
   end

   // Next state; disarm overrides everything else
   always_comb begin
      state_nx = state_q;
      trig_nx  = 1'b0;
      if (disarm_c) begin
         state_nx = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (rearm_c || auto_q) state_nx = ST_ARMED;
            ST_ARMED:   if (event_c) begin
                           state_nx = ST_HOLDOFF;
                           trig_nx  = 1'b1;
                        end
            ST_HOLDOFF: if (hcnt_q == '0) state_nx = auto_q ? ST_ARMED : ST_IDLE;
            default:    state_nx = ST_IDLE;
         endcase
      end
   end

   // Trigger outputs, holdoff counter, timestamp and count
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         trig_o     <= 1'b0;
         trig_src_o <= '0;
         armed_o    <= 1'b0;
         hcnt_q     <= '0;
         cnt_q      <= '0;
         ts_q       <= '0;
         tcnt_q     <= '0;
      end else begin
         trig_o  <= trig_nx;
         armed_o <= (state_nx == ST_ARMED);
         cnt_q   <= cnt_q + 64'd1;
         if (trig_nx) begin
            hcnt_q     <= holdoff_q;
            trig_src_o <= ev_mask_c;
            ts_q       <= cnt_q;
            tcnt_q     <= tcnt_q + 32'd1;
         end else if ((state_q == ST_HOLDOFF) && (hcnt_q != '0)) begin
            hcnt_q <= hcnt_q - HOLDOFF_W'(1);
         end
      end
   end

   always_comb begin
      rd_c = '0;
      case (addr)
         16'h100: rd_c = 32'(state_q);
         16'h104: rd_c = 32'(auto_q);
         16'h108: rd_c = 32'(en_q);
         16'h10C: rd_c = 32'(holdoff_q);
         16'h15C: rd_c = ts_q[31:0];
         16'h160: rd_c = ts_q[63:32];
         16'h164: rd_c = tcnt_q;
         16'h168: rd_c = 32'(trig_src_o);
         16'h220: rd_c = 32'(CHANNELS);
         16'h224: rd_c = 32'(DATA_W);
         default: ;
      endcase
      for (int k = 0; k < CHANNELS; k++) begin
         if (addr == 16'(16'h118 + 8*k)) rd_c = 32'(thresh_q[k]);
         if (addr == 16'(16'h11C + 8*k)) rd_c = 32'(hyst_q[k]);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ack   <= 1'b0;
         rdata <= '0;
      end else begin
         ack   <= wen | ren;
         rdata <= ren ? rd_c : 32'd0;
      end
   end

endmodule
